reg_file_mp: RTL and testbench

//  Parametrised multi-port integer register file with per-register scoreboard. Successor to the

---
 rtl/reg_file_mp.sv | 100 ++++++++++
 tb/tb_reg_file_mp.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with per-register pending-write scoreboard.
// Reads are combinational with optional same-cycle write forwarding; writes and scoreboard update on clk.
module reg_file_mp #(
   parameter int XLEN     = 64,
   parameter int NREG     = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD-1:0]      rd_en,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr,
   output logic [NREG-1:0]     busy_vec
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   logic [AW-1:0]   wa [NWR];
   logic [XLEN-1:0] wd [NWR];
   logic [AW-1:0]   ra [NRD];

   // Register 0 is hardwired when ZERO_REG is set; nothing may target it.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return !((ZERO_REG != 0) && (a == '0));
   endfunction

   always_comb begin
      for (int j = 0; j < NWR; j++) begin
         wa[j] = wr_addr[j*AW +: AW];
         wd[j] = wr_data[j*XLEN +: XLEN];
      end
      for (int i = 0; i < NRD; i++) begin
         ra[i] = rd_addr[i*AW +: AW];
      end
   end

   // Ascending port order lets the highest-index writer win; alloc is applied last so a new producer
   // keeps the register pending even when an older result lands in the same cycle.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j] && addr_ok(wa[j])) begin
            regs_d[wa[j]] = wd[j];
            busy_d[wa[j]] = 1'b0;
         end
      end
      if (alloc_en && addr_ok(alloc_addr)) begin
         busy_d[alloc_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   // Read outputs are gated by rst so forwarded write data cannot leak out while in reset.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (rst && rd_en[i] && addr_ok(ra[i])) begin
            rd_data[i*XLEN +: XLEN] = regs_q[ra[i]];
            rd_busy[i]              = busy_q[ra[i]];
            if (BYPASS != 0) begin
               for (int j = 0; j < NWR; j++) begin
                  if (wr_en[j] && (wa[j] == ra[i])) begin
                     rd_data[i*XLEN +: XLEN] = wd[j];
                     rd_busy[i]              = 1'b0;
                  end
               end
            end
         end
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a 2R2W forwarding instance and a 1R1W non-forwarding instance
// share write port 0 and alloc; expected read results are queued by the stimulus and popped by a monitor.
module tb_reg_file_mp;

   localparam int XLEN = 64;
   localparam int AW   = 5;

   typedef struct {
      logic [XLEN-1:0] d;
      logic            b;
      string           nm;
   } exp_t;

   typedef struct {
      logic [31:0] v;
      string       nm;
   } bexp_t;

   logic             clk;
   logic             rst;
   logic [1:0]       rd_en;
   logic [2*AW-1:0]  rd_addr;
   logic [2*XLEN-1:0] rd_data;
   logic [1:0]       rd_busy;
   logic [1:0]       wr_en;
   logic [2*AW-1:0]  wr_addr;
   logic [2*XLEN-1:0] wr_data;
   logic             alloc_en;
   logic [AW-1:0]    alloc_addr;
   logic [31:0]      busy_vec;

   logic [0:0]       nb_rd_en;
   logic [AW-1:0]    nb_rd_addr;
   logic [XLEN-1:0]  nb_rd_data;
   logic [0:0]       nb_rd_busy;
   logic [31:0]      nb_busy_vec;

   logic             chk_bv;

   exp_t  q0[$];
   exp_t  q1[$];
   exp_t  qn[$];
   bexp_t qb[$];

   int n_cmp  = 0;
   int n_fail = 0;

   reg_file_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .busy_vec   (busy_vec)
   );

   reg_file_mp #(.XLEN(64), .NREG(32), .NRD(1), .NWR(1), .ZERO_REG(1), .BYPASS(0)) u_nb (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (nb_rd_en),
      .rd_addr    (nb_rd_addr),
      .rd_data    (nb_rd_data),
      .rd_busy    (nb_rd_busy),
      .wr_en      (wr_en[0:0]),
      .wr_addr    (wr_addr[AW-1:0]),
      .wr_data    (wr_data[XLEN-1:0]),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .busy_vec   (nb_busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [XLEN-1:0] ad, input logic ab,
                      input logic [XLEN-1:0] ed, input logic eb);
      n_cmp++;
      if (ad !== ed || ab !== eb) begin
         n_fail++;
         $display("FAIL %s: got data=%h busy=%b, expected data=%h busy=%b", nm, ad, ab, ed, eb);
      end
   endtask

   task automatic fail_missing(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no matching expectation/response", nm);
   endtask

   // Monitor: pops one expectation per enabled read port at mid-cycle.
   always @(negedge clk) begin
      exp_t  e;
      bexp_t be;
      if (rd_en[0]) begin
         if (q0.size() == 0) fail_missing("port0 unexpected read");
         else begin
            e = q0.pop_front();
            cmp(e.nm, rd_data[XLEN-1:0], rd_busy[0], e.d, e.b);
         end
      end
      if (rd_en[1]) begin
         if (q1.size() == 0) fail_missing("port1 unexpected read");
         else begin
            e = q1.pop_front();
            cmp(e.nm, rd_data[2*XLEN-1:XLEN], rd_busy[1], e.d, e.b);
         end
      end
      if (nb_rd_en[0]) begin
         if (qn.size() == 0) fail_missing("nobypass unexpected read");
         else begin
            e = qn.pop_front();
            cmp(e.nm, nb_rd_data, nb_rd_busy[0], e.d, e.b);
         end
      end
      if (chk_bv) begin
         if (qb.size() == 0) fail_missing("busy_vec unexpected check");
         else begin
            be = qb.pop_front();
            n_cmp++;
            if (busy_vec !== be.v) begin
               n_fail++;
               $display("FAIL %s: got busy_vec=%h, expected %h", be.nm, busy_vec, be.v);
            end
         end
      end
   end

   task automatic clr();
      rd_en      = '0;
      wr_en      = '0;
      alloc_en   = 1'b0;
      nb_rd_en   = '0;
      chk_bv     = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clr();
   endtask

   task automatic rd(input int p, input int a, input logic [XLEN-1:0] d, input logic b, input string nm);
      exp_t e;
      e.d = d; e.b = b; e.nm = nm;
      rd_en[p] = 1'b1;
      rd_addr[p*AW +: AW] = a[AW-1:0];
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic nrd(input int a, input logic [XLEN-1:0] d, input logic b, input string nm);
      exp_t e;
      e.d = d; e.b = b; e.nm = nm;
      nb_rd_en[0] = 1'b1;
      nb_rd_addr  = a[AW-1:0];
      qn.push_back(e);
   endtask

   task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
      wr_en[p] = 1'b1;
      wr_addr[p*AW +: AW] = a[AW-1:0];
      wr_data[p*XLEN +: XLEN] = d;
   endtask

   task automatic alloc(input int a);
      alloc_en   = 1'b1;
      alloc_addr = a[AW-1:0];
   endtask

   task automatic bv(input logic [31:0] v, input string nm);
      bexp_t be;
      be.v = v; be.nm = nm;
      chk_bv = 1'b1;
      qb.push_back(be);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0; nb_rd_addr = '0;
      clr();
      step();

      // Reset held: writes and allocs must be ignored, outputs zero.
      wr(0, 5, 64'hAAAA_AAAA_AAAA_AAAA);
      wr(1, 6, 64'hBBBB_BBBB_BBBB_BBBB);
      alloc(5);
      rd(0, 5, 64'h0, 1'b0, "rst_rd_r5_during_write");
      rd(1, 6, 64'h0, 1'b0, "rst_rd_r6_during_write");
      nrd(5, 64'h0, 1'b0, "rst_nb_rd_r5");
      bv(32'h0, "rst_busy_vec");
      step();
      rd(0, 5, 64'h0, 1'b0, "rst_rd_r5_after_edge");
      rd(1, 6, 64'h0, 1'b0, "rst_rd_r6_after_edge");
      bv(32'h0, "rst_busy_vec_after_edge");
      step();
      rst = 1'b1;

      for (int a = 1; a <= 31; a += 2) begin
         rd(0, a, 64'h0, 1'b0, $sformatf("post_rst_r%0d", a));
         if (a + 1 <= 31) rd(1, a + 1, 64'h0, 1'b0, $sformatf("post_rst_r%0d", a + 1));
         step();
      end

      // Write r5 with same-cycle read: forwarded on the bypass build, old value without.
      wr(0, 5, 64'hDEAD_BEEF_0000_0001);
      rd(0, 5, 64'hDEAD_BEEF_0000_0001, 1'b0, "bypass_r5_cycle_n");
      rd(1, 4, 64'h0, 1'b0, "r4_untouched");
      nrd(5, 64'h0, 1'b0, "nobypass_r5_cycle_n");
      step();
      rd(0, 5, 64'hDEAD_BEEF_0000_0001, 1'b0, "r5_cycle_n1");
      nrd(5, 64'hDEAD_BEEF_0000_0001, 1'b0, "nobypass_r5_cycle_n1");
      step();

      // Zero register.
      wr(0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
      alloc(0);
      rd(0, 0, 64'h0, 1'b0, "r0_write_same_cycle_p0");
      rd(1, 0, 64'h0, 1'b0, "r0_write_same_cycle_p1");
      bv(32'h0, "busy_vec_before_r0_alloc");
      step();
      rd(0, 0, 64'h0, 1'b0, "r0_after_write");
      nrd(0, 64'h0, 1'b0, "nobypass_r0_after_write");
      bv(32'h0, "busy_vec_r0_alloc_dropped");
      step();

      // Two write ports colliding on r7: highest index wins.
      wr(0, 7, 64'h11);
      wr(1, 7, 64'h22);
      rd(0, 7, 64'h22, 1'b0, "collide_bypass_r7");
      nrd(7, 64'h0, 1'b0, "nobypass_r7_cycle_n");
      step();
      rd(0, 7, 64'h22, 1'b0, "collide_stored_r7");
      nrd(7, 64'h11, 1'b0, "nobypass_r7_stored");
      step();

      // Scoreboard: alloc r9, then write it back three cycles later on port 1.
      alloc(9);
      rd(0, 9, 64'h0, 1'b0, "alloc_r9_cycle_n");
      bv(32'h0, "busy_vec_alloc_cycle_n");
      step();
      rd(0, 9, 64'h0, 1'b1, "busy_r9_n1");
      nrd(9, 64'h0, 1'b1, "nobypass_busy_r9_n1");
      bv(32'h0000_0200, "busy_vec_n1");
      step();
      rd(1, 9, 64'h0, 1'b1, "busy_r9_n2_p1");
      step();
      wr(1, 9, 64'h42);
      rd(0, 9, 64'h42, 1'b0, "writeback_bypass_r9_n3");
      bv(32'h0000_0200, "busy_vec_n3");
      step();
      rd(0, 9, 64'h42, 1'b0, "r9_n4");
      nrd(9, 64'h0, 1'b1, "nobypass_r9_still_busy");
      bv(32'h0, "busy_vec_n4");
      step();

      // Alloc and write to the same register: new producer keeps it pending.
      alloc(9);
      wr(0, 9, 64'h43);
      rd(0, 9, 64'h43, 1'b0, "alloc_write_bypass_r9");
      step();
      rd(0, 9, 64'h43, 1'b1, "alloc_write_r9_busy");
      nrd(9, 64'h43, 1'b1, "nobypass_alloc_write_r9");
      bv(32'h0000_0200, "busy_vec_alloc_write");
      step();

      // Build busy r3/r4 with r3 holding 5, then reset mid-cycle.
      alloc(3);
      wr(0, 3, 64'h5);
      step();
      alloc(4);
      step();
      rd(0, 3, 64'h5, 1'b1, "r3_before_reset");
      rd(1, 4, 64'h0, 1'b1, "r4_before_reset");
      bv(32'h0000_0218, "busy_vec_before_reset");
      step();
      rst = 1'b0;
      wr(0, 3, 64'h77);
      rd(0, 3, 64'h0, 1'b0, "midrst_r3");
      rd(1, 9, 64'h0, 1'b0, "midrst_r9");
      nrd(3, 64'h0, 1'b0, "midrst_nobypass_r3");
      bv(32'h0, "midrst_busy_vec");
      step();
      rst = 1'b1;
      rd(0, 3, 64'h0, 1'b0, "after_rst_r3");
      rd(1, 7, 64'h0, 1'b0, "after_rst_r7");
      nrd(9, 64'h0, 1'b0, "after_rst_nobypass_r9");
      bv(32'h0, "after_rst_busy_vec");
      step();
      step();

      if (q0.size() != 0 || q1.size() != 0 || qn.size() != 0 || qb.size() != 0) begin
         fail_missing($sformatf("leftover expectations q0=%0d q1=%0d qn=%0d qb=%0d",
                                q0.size(), q1.size(), qn.size(), qb.size()));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
